// File: rtl/lut_table_pkg.sv
// Shared definitions for the lut_table block.
//  - lut_op_e : write opcodes carried on wr_op
package lut_table_pkg;

  typedef enum logic [1:0] {
    LUT_OP_INS = 2'b00,  // insert, or update the data of a present key
    LUT_OP_DEL = 2'b01,  // delete one key
    LUT_OP_CLR = 2'b10,  // invalidate and zero every entry
    LUT_OP_RSV = 2'b11   // reserved, treated as a no-op
  } lut_op_e;

endpackage

// File: rtl/lut_free_finder.sv
// Combinational priority encoder that finds the lowest-index free table entry.
//  vld       in  N  per-entry valid mask
//  free_oh   out N  one-hot lowest-index entry with vld=0 (all zero when full)
//  any_free  out 1  at least one entry is free
module lut_free_finder #(
  parameter int N = 2
) (
  input  logic [N-1:0] vld,
  output logic [N-1:0] free_oh,
  output logic         any_free
);

  // Adding one ripples through the trailing ones and sets the lowest zero;
  // masking with ~vld keeps just that bit. A full mask wraps to zero.
  assign free_oh  = ~vld & (vld + N'(1));
  assign any_free = ~&vld;

endmodule

// File: rtl/lut_table.sv
// Writable key/data table producing the flat {key,data} LUT bus for the
// downstream decoder, plus a one-stage registered lookup port.
//  clk, rst_n                 clock, asynchronous active-low reset
//  wr_valid/wr_ready/wr_op    write request (insert/update, delete, clear all)
//  wr_key/wr_data             write operands
//  wr_err                     one-cycle pulse: insert rejected, table full
//  lk_valid/lk_ready          lookup request handshake
//  lk_key/lk_def              lookup key and data returned on a miss
//  rsp_valid/rsp_ready        lookup response handshake
//  rsp_hit/rsp_data           response contents
//  lut/lut_vld                flat table and per-entry valid mask
//  count/full                 number of valid entries, table full flag
module lut_table
  import lut_table_pkg::*;
#(
  parameter int NR_KEY     = 2,
  parameter int KEY_WIDTH  = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       wr_valid,
  output logic                                       wr_ready,
  input  logic [1:0]                                 wr_op,
  input  logic [KEY_WIDTH-1:0]                       wr_key,
  input  logic [DATA_WIDTH-1:0]                      wr_data,
  output logic                                       wr_err,
  input  logic                                       lk_valid,
  output logic                                       lk_ready,
  input  logic [KEY_WIDTH-1:0]                       lk_key,
  input  logic [DATA_WIDTH-1:0]                      lk_def,
  output logic                                       rsp_valid,
  input  logic                                       rsp_ready,
  output logic                                       rsp_hit,
  output logic [DATA_WIDTH-1:0]                      rsp_data,
  output logic [NR_KEY*(KEY_WIDTH+DATA_WIDTH)-1:0]   lut,
  output logic [NR_KEY-1:0]                          lut_vld,
  output logic [$clog2(NR_KEY+1)-1:0]                count,
  output logic                                       full
);

  localparam int P  = KEY_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(NR_KEY+1);

  logic                  vld_reg  [NR_KEY];
  logic [KEY_WIDTH-1:0]  key_reg  [NR_KEY];
  logic [DATA_WIDTH-1:0] data_reg [NR_KEY];

  logic [NR_KEY-1:0]     wr_match;
  logic [NR_KEY-1:0]     lk_match;
  logic [NR_KEY-1:0]     free_oh;
  logic                  any_free;

  logic                  wr_fire;
  logic                  op_ins;
  logic                  op_del;
  logic                  op_clr;
  logic                  wr_hit;
  logic                  lk_fire;

  logic                  wr_err_reg;
  logic                  rsp_valid_reg;
  logic                  rsp_hit_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;

  logic [CW-1:0]         count_next;
  logic [DATA_WIDTH-1:0] lk_data_or;

  assign wr_ready = 1'b1;
  assign wr_fire  = wr_valid & wr_ready;
  assign op_ins   = (wr_op == LUT_OP_INS);
  assign op_del   = (wr_op == LUT_OP_DEL);
  assign op_clr   = (wr_op == LUT_OP_CLR);
  assign wr_hit   = |wr_match;

  lut_free_finder #(.N(NR_KEY)) u_free_finder (
    .vld      (lut_vld),
    .free_oh  (free_oh),
    .any_free (any_free)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NR_KEY; gi++) begin : g_entry
      assign wr_match[gi] = vld_reg[gi] && (key_reg[gi] == wr_key);
      assign lk_match[gi] = vld_reg[gi] && (key_reg[gi] == lk_key);
      assign lut_vld[gi]  = vld_reg[gi];
      // Storage is already zero when invalid; gating keeps the bus clean
      // regardless.
      assign lut[P*(gi+1)-1:P*gi] = vld_reg[gi] ? {key_reg[gi], data_reg[gi]} : '0;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_reg[gi]  <= 1'b0;
          key_reg[gi]  <= '0;
          data_reg[gi] <= '0;
        end else if (wr_fire) begin
          if (op_clr || (op_del && wr_match[gi])) begin
            vld_reg[gi]  <= 1'b0;
            key_reg[gi]  <= '0;
            data_reg[gi] <= '0;
          end else if (op_ins && wr_match[gi]) begin
            data_reg[gi] <= wr_data;
          end else if (op_ins && !wr_hit && free_oh[gi]) begin
            vld_reg[gi]  <= 1'b1;
            key_reg[gi]  <= wr_key;
            data_reg[gi] <= wr_data;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = '0;
    lk_data_or = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      count_next = count_next + CW'(vld_reg[i]);
      if (lk_match[i]) lk_data_or = lk_data_or | data_reg[i];
    end
  end

  assign count = count_next;
  assign full  = (count_next == CW'(NR_KEY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err_reg <= 1'b0;
    else        wr_err_reg <= wr_fire && op_ins && !wr_hit && !any_free;
  end
  assign wr_err = wr_err_reg;

  // Lookup stage reads the table before any same-edge write lands.
  assign lk_ready = !rsp_valid_reg || rsp_ready;
  assign lk_fire  = lk_valid && lk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_hit_reg   <= 1'b0;
      rsp_data_reg  <= '0;
    end else if (lk_fire) begin
      rsp_valid_reg <= 1'b1;
      rsp_hit_reg   <= |lk_match;
      rsp_data_reg  <= (|lk_match) ? lk_data_or : lk_def;
    end else if (rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_hit   = rsp_hit_reg;
  assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_lut_table.sv
module tb_lut_table;
  import lut_table_pkg::*;

  localparam int NK = 4;
  localparam int KW = 4;
  localparam int DW = 8;
  localparam int P  = KW + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready;
  logic [1:0]    wr_op;
  logic [KW-1:0] wr_key;
  logic [DW-1:0] wr_data;
  logic          wr_err;
  logic          lk_valid, lk_ready;
  logic [KW-1:0] lk_key;
  logic [DW-1:0] lk_def;
  logic          rsp_valid, rsp_ready, rsp_hit;
  logic [DW-1:0] rsp_data;
  logic [NK*P-1:0] lut;
  logic [NK-1:0] lut_vld;
  logic [2:0]    count;
  logic          full;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the table and the response scoreboard.
  logic          m_vld  [NK];
  logic [KW-1:0] m_key  [NK];
  logic [DW-1:0] m_data [NK];
  logic          m_err_exp;
  logic [DW:0]   sb_q [$];

  always #5 clk = ~clk;

  lut_table #(.NR_KEY(NK), .KEY_WIDTH(KW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_op(wr_op),
    .wr_key(wr_key), .wr_data(wr_data), .wr_err(wr_err),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key), .lk_def(lk_def),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_data(rsp_data),
    .lut(lut), .lut_vld(lut_vld), .count(count), .full(full)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      m_vld[i] = 1'b0; m_key[i] = '0; m_data[i] = '0;
    end
    m_err_exp = 1'b0;
    sb_q.delete();
  endtask

  // Monitor on the falling edge: compare table state, retire responses,
  // enqueue expectations of lookups accepted at the coming edge, then apply
  // the write accepted at the coming edge to the model.
  always @(negedge clk) begin
    logic [NK*P-1:0] e_lut;
    logic [NK-1:0]   e_vld;
    int              e_cnt;
    int              hit_idx;
    int              free_idx;
    logic            h;
    logic [DW-1:0]   d;
    logic [DW:0]     r;
    if (!rst_n) begin
      model_reset();
    end else begin
      e_lut = '0; e_vld = '0; e_cnt = 0;
      for (int i = 0; i < NK; i++) begin
        e_vld[i] = m_vld[i];
        if (m_vld[i]) begin
          e_lut[P*i +: P] = {m_key[i], m_data[i]};
          e_cnt++;
        end
      end
      check("mon_lut", 64'(lut), 64'(e_lut));
      check("mon_lut_vld", 64'(lut_vld), 64'(e_vld));
      check("mon_count", 64'(count), 64'(e_cnt));
      check("mon_full", 64'(full), 64'(e_cnt == NK));
      check("mon_wr_err", 64'(wr_err), 64'(m_err_exp));
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_rsp", 64'(1), 64'(0));
        end else begin
          r = sb_q.pop_front();
          $display("rsp  hit=%0d data=%h (expected hit=%0d data=%h)", rsp_hit, rsp_data, r[DW], r[DW-1:0]);
          check("sb_rsp", 64'({rsp_hit, rsp_data}), 64'(r));
        end
      end
      if (lk_valid && lk_ready) begin
        h = 1'b0; d = '0;
        for (int i = 0; i < NK; i++)
          if (m_vld[i] && m_key[i] == lk_key) begin h = 1'b1; d = d | m_data[i]; end
        sb_q.push_back({h, h ? d : lk_def});
      end
      m_err_exp = 1'b0;
      if (wr_valid) begin
        hit_idx = -1; free_idx = -1;
        for (int i = NK-1; i >= 0; i--) begin
          if (m_vld[i] && m_key[i] == wr_key) hit_idx = i;
          if (!m_vld[i]) free_idx = i;
        end
        case (wr_op)
          2'b00: begin
            if (hit_idx >= 0) m_data[hit_idx] = wr_data;
            else if (free_idx >= 0) begin
              m_vld[free_idx] = 1'b1; m_key[free_idx] = wr_key; m_data[free_idx] = wr_data;
            end else m_err_exp = 1'b1;
          end
          2'b01: if (hit_idx >= 0) begin
            m_vld[hit_idx] = 1'b0; m_key[hit_idx] = '0; m_data[hit_idx] = '0;
          end
          2'b10: for (int i = 0; i < NK; i++) begin
            m_vld[i] = 1'b0; m_key[i] = '0; m_data[i] = '0;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] op, input logic [KW-1:0] k, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_op = op; wr_key = k; wr_data = d;
    $display("wr   op=%b key=%h data=%h", op, k, d);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic lk(input logic [KW-1:0] k, input logic [DW-1:0] def);
    int waited;
    lk_valid = 1'b1; lk_key = k; lk_def = def;
    waited = 0;
    while (!lk_ready && waited < 20) begin step(); waited++; end
    if (!lk_ready) check("lk_ready_timeout", 64'(lk_ready), 64'(1));
    $display("lk   key=%h def=%h", k, def);
    step();
    lk_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_op = 2'b00; wr_key = '0; wr_data = '0;
    lk_valid = 1'b0; lk_key = '0; lk_def = '0; rsp_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_lut", 64'(lut), 64'(0));
    check("rst_lut_vld", 64'(lut_vld), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_full", 64'(full), 64'(0));
    check("rst_wr_err", 64'(wr_err), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp", 64'({rsp_hit, rsp_data}), 64'(0));
    check("wr_ready", 64'(wr_ready), 64'(1));
    rst_n = 1'b1;
    step();

    // Miss on the empty table returns the default.
    lk(4'h3, 8'hEE);
    check("t1_rsp_valid", 64'(rsp_valid), 64'(1));
    check("t1_rsp", 64'({rsp_hit, rsp_data}), 64'({1'b0, 8'hEE}));

    wr(LUT_OP_INS, 4'h1, 8'hAA);
    wr(LUT_OP_INS, 4'h2, 8'hBB);
    check("t2_lut_vld", 64'(lut_vld), 64'(4'b0011));
    check("t2_entry0", 64'(lut[11:0]), 64'(12'h1AA));
    check("t2_entry1", 64'(lut[23:12]), 64'(12'h2BB));
    lk(4'h2, 8'h00);
    check("t2_rsp", 64'({rsp_valid, rsp_hit, rsp_data}), 64'({2'b11, 8'hBB}));

    wr(LUT_OP_INS, 4'h1, 8'hCC);
    check("t3_entry0", 64'(lut[11:0]), 64'(12'h1CC));
    check("t3_count", 64'(count), 64'(2));

    wr(LUT_OP_INS, 4'h3, 8'h33);
    wr(LUT_OP_INS, 4'h4, 8'h44);
    check("t4_full", 64'(full), 64'(1));
    wr(LUT_OP_INS, 4'h9, 8'h11);
    check("t4_wr_err", 64'(wr_err), 64'(1));
    check("t4_lut", 64'(lut), 64'(48'h444_333_2BB_1CC));
    step();
    check("t4_wr_err_pulse", 64'(wr_err), 64'(0));

    wr(LUT_OP_DEL, 4'h2, 8'h00);
    check("t5_del_vld", 64'(lut_vld), 64'(4'b1101));
    check("t5_del_entry1", 64'(lut[23:12]), 64'(0));
    wr(LUT_OP_INS, 4'h7, 8'h77);
    check("t5_reuse_vld", 64'(lut_vld), 64'(4'b1111));
    check("t5_reuse_entry1", 64'(lut[23:12]), 64'(12'h777));
    wr(LUT_OP_DEL, 4'h5, 8'h00);
    check("t5_absent_lut", 64'(lut), 64'(48'h444_333_777_1CC));
    check("t5_absent_err", 64'(wr_err), 64'(0));
    wr(LUT_OP_RSV, 4'h1, 8'h00);
    check("t5_rsv_lut", 64'(lut), 64'(48'h444_333_777_1CC));

    // Free entry 3 for the same-cycle insert+lookup below.
    wr(LUT_OP_DEL, 4'h4, 8'h00);

    // Backpressure: response held while the next lookup waits.
    rsp_ready = 1'b0;
    lk_valid = 1'b1; lk_key = 4'h7; lk_def = 8'h00;
    step();
    lk_key = 4'h1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_lk_ready_low", 64'(lk_ready), 64'(0));
      check("t6_hold", 64'({rsp_valid, rsp_hit, rsp_data}), 64'({2'b11, 8'h77}));
    end
    rsp_ready = 1'b1;
    lk_key = 4'h8; lk_def = 8'h5A;
    wr_valid = 1'b1; wr_op = LUT_OP_INS; wr_key = 4'h8; wr_data = 8'h88;
    step();
    lk_valid = 1'b0; wr_valid = 1'b0;
    check("t6_pre_write_lookup", 64'({rsp_valid, rsp_hit, rsp_data}), 64'({2'b10, 8'h5A}));
    check("t6_insert_entry3", 64'(lut[47:36]), 64'(12'h888));

    wr(LUT_OP_CLR, 4'h0, 8'h00);
    check("t6_clr_count", 64'(count), 64'(0));
    check("t6_clr_lut", 64'({lut_vld, lut}), 64'(0));

    // Reset during a held response drops it at once.
    rsp_ready = 1'b0;
    lk(4'h1, 8'h33);
    check("t6_rsp_pending", 64'(rsp_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("t6_rst_count", 64'(count), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    step();
    lk(4'h1, 8'h33);
    repeat (3) step();
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
